// File: rtl/coeff_update_ctrl.sv
// coeff_update_ctrl: captures a completed SPI coefficient frame into a staging
// register and commits it to the biquad cascade only on a sample boundary.
// Optional statistics counters are built when COEFF_STATS_EN is defined.
module coeff_update_ctrl #(
  parameter int                 NUM_STAGES       = 3,
  parameter int                 COEFFS_PER_STAGE = 7,
  parameter int                 COEFF_W          = 16,
  parameter logic [COEFF_W-1:0] RESET_C0         = 16'h4000,
  localparam int                FRAME_W          = NUM_STAGES * COEFFS_PER_STAGE * COEFF_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [FRAME_W-1:0] spi_data,
  input  logic               spi_valid,
  input  logic               sample_tick,
  input  logic               hold,
  input  logic               clear_overrun,
  output logic [FRAME_W-1:0] coeffs_active,
  output logic               coeff_load,
  output logic               pending,
  output logic               overrun
`ifdef COEFF_STATS_EN
  ,
  output logic [7:0]         commit_count,
  output logic [7:0]         drop_count
`endif
);

  localparam int STAGE_W = COEFFS_PER_STAGE * COEFF_W;

  // Unity passthrough: coefficient 0 of each stage is RESET_C0, the rest zero.
  function automatic logic [FRAME_W-1:0] reset_frame();
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int unsigned s = 0; s < NUM_STAGES; s++)
      f[FRAME_W-1-s*STAGE_W -: COEFF_W] = RESET_C0;
    return f;
  endfunction

  localparam logic [FRAME_W-1:0] RESET_FRAME = reset_frame();

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t             state, next_state;
  logic               v1, v2, v3;
  logic               frame_edge;
  logic               capture, commit, ovr_set;
  logic [FRAME_W-1:0] staging;

  // Two-flop synchronizer for spi_valid plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= spi_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  assign frame_edge = v2 & ~v3;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state and capture/commit/overrun strobes.
  // A frame_edge coinciding with a commit commits the old staging value and
  // captures the new frame on the same edge, so PENDING is held without overrun.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    commit     = 1'b0;
    ovr_set    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_edge) begin
          capture    = 1'b1;
          next_state = PENDING;
        end
      end
      PENDING: begin
        commit = sample_tick & ~hold;
        if (frame_edge) begin
          capture = 1'b1;
          ovr_set = ~commit;
        end else if (commit) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign pending = (state == PENDING);

  // Staging capture, active commit, load pulse and sticky overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      staging       <= '0;
      coeffs_active <= RESET_FRAME;
      coeff_load    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (capture) staging <= spi_data;
      if (commit)  coeffs_active <= staging;
      coeff_load <= commit;
      if (ovr_set)            overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

`ifdef COEFF_STATS_EN
  // Commit counter wraps; drop counter saturates and is cleared with overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_count <= '0;
      drop_count   <= '0;
    end else begin
      if (coeff_load) commit_count <= commit_count + 8'd1;
      if (ovr_set) begin
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else if (clear_overrun) begin
        drop_count <= '0;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
